// File: rtl/vlc_bit_packer_if.sv
// vlc_bit_packer_if
//   Codeword-in / packed-word-out bundle for vlc_bit_packer.
//   Input side : in_valid, in_ready, in_code[MAX_LEN], in_len[LEN_W], in_flush
//   Output side: out_valid, out_ready, out_data[DATA_W], out_bytes[3], out_last
//   Status     : len_err (sticky codeword-length overflow)
//   Modports   : slave  - the packer's view (consumes codewords, drives words)
//                master - the environment's view (drives codewords, takes words)
`timescale 1ns/1ps

interface vlc_bit_packer_if #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [MAX_LEN-1:0] in_code;
    logic [LEN_W-1:0]   in_len;
    logic               in_flush;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic [2:0]         out_bytes;
    logic               out_last;
    logic               len_err;

    modport slave (
        input  in_valid, in_code, in_len, in_flush, out_ready,
        output in_ready, out_valid, out_data, out_bytes, out_last, len_err
    );

    modport master (
        output in_valid, in_code, in_len, in_flush, out_ready,
        input  in_ready, out_valid, out_data, out_bytes, out_last, len_err
    );
endinterface

// File: rtl/vlc_bit_packer.sv
// vlc_bit_packer
//   Variable-length-code bitstream writer. Right-aligned codewords (in_code, in_len)
//   are appended MSB-first into an accumulator and emitted as DATA_W-bit words on a
//   valid/ready stream. A beat with in_flush closes the frame: remaining bits go out
//   zero-padded with out_bytes = ceil(bits/8) and out_last = 1.
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset; discards all buffered bits
//   bus       vlc_bit_packer_if.slave (codeword input, word output, len_err)
//   bit_count bits accepted in the current frame (only with VLC_PACK_BITCNT_EN)
// Configuration
//   VLC_PACK_BITCNT_EN  define to add the bit_count output and its counter.
`timescale 1ns/1ps

module vlc_bit_packer #(
    parameter int DATA_W  = 32,
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    vlc_bit_packer_if.slave    bus
`ifdef VLC_PACK_BITCNT_EN
    ,
    output logic [31:0]        bit_count
`endif
);
    // The accumulator only takes a beat while fill < DATA_W, so it never holds
    // more than DATA_W-1+MAX_LEN bits.
    localparam int ACC_W  = DATA_W + MAX_LEN - 1;
    localparam int FILL_W = $clog2(ACC_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(DATA_W);
    localparam logic [2:0]        FULL_BYTES = 3'(DATA_W / 8);

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_nxt;
    logic [ACC_W-1:0]   acc_drained;
    logic [ACC_W-1:0]   ins_bits;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_nxt;
    logic [FILL_W-1:0]  fill_drained;
    logic [FILL_W-1:0]  ins_shift;

    logic               ready_en;
    logic               len_over;
    logic [LEN_W-1:0]   len_clamped;
    logic [MAX_LEN-1:0] code_masked;
    logic               accept;
    logic               out_free;
    logic               handoff_last;

    logic               load;
    logic [DATA_W-1:0]  load_data;
    logic [2:0]         load_bytes;
    logic               load_last;

    // ready_en holds in_ready low through reset and releases it one edge later.
    assign bus.in_ready = ready_en & (state == ST_RUN) & (fill < FILL_FULL);

    always_comb begin
        len_over     = bus.in_len > LEN_W'(MAX_LEN);
        len_clamped  = len_over ? LEN_W'(MAX_LEN) : bus.in_len;
        code_masked  = bus.in_code & ~({MAX_LEN{1'b1}} << len_clamped);
        accept       = bus.in_valid & bus.in_ready;
        out_free     = !bus.out_valid | bus.out_ready;
        handoff_last = bus.out_valid & bus.out_ready & bus.out_last;

        // Output-register load, evaluated on the pre-accept accumulator.
        load         = 1'b0;
        load_data    = acc[ACC_W-1 -: DATA_W];
        load_bytes   = FULL_BYTES;
        load_last    = 1'b0;
        acc_drained  = acc;
        fill_drained = fill;
        // Once the frame's last word sits in the register nothing else may load
        // until it is taken; otherwise an empty FLUSH would emit a second last word.
        if (out_free && !(bus.out_valid && bus.out_last)) begin
            if (fill >= FILL_FULL) begin
                load         = 1'b1;
                load_last    = (state == ST_FLUSH) && (fill == FILL_FULL);
                acc_drained  = acc << DATA_W;
                fill_drained = fill - FILL_FULL;
            end else if (state == ST_FLUSH) begin
                // Bits below fill are always zero, so the top slice is already padded.
                load         = 1'b1;
                load_last    = 1'b1;
                load_bytes   = 3'(({1'b0, fill} + (FILL_W+1)'(7)) >> 3);
                acc_drained  = '0;
                fill_drained = '0;
            end
        end

        // New code lands directly under the bits already held.
        ins_shift = FILL_W'(ACC_W) - fill_drained - FILL_W'(len_clamped);
        ins_bits  = {{(ACC_W-MAX_LEN){1'b0}}, code_masked} << ins_shift;

        acc_nxt  = acc_drained;
        fill_nxt = fill_drained;
        if (accept) begin
            acc_nxt  = acc_drained | ins_bits;
            fill_nxt = fill_drained + FILL_W'(len_clamped);
        end

        state_nxt = state;
        case (state)
            ST_RUN:   if (accept && bus.in_flush) state_nxt = ST_FLUSH;
            ST_FLUSH: if (handoff_last)           state_nxt = ST_RUN;
            default:                              state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            acc      <= '0;
            fill     <= '0;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nxt;
            acc      <= acc_nxt;
            fill     <= fill_nxt;
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_bytes <= '0;
            bus.out_last  <= 1'b0;
        end else if (load) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= load_data;
            bus.out_bytes <= load_bytes;
            bus.out_last  <= load_last;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.len_err <= 1'b0;
        end else if (accept && len_over) begin
            bus.len_err <= 1'b1;
        end
    end

`ifdef VLC_PACK_BITCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_count <= '0;
        end else if (handoff_last) begin
            bit_count <= '0;
        end else if (accept) begin
            bit_count <= bit_count + 32'(len_clamped);
        end
    end
`endif

endmodule

// File: tb/tb_vlc_bit_packer.sv
// tb_vlc_bit_packer
//   Self-checking bench for vlc_bit_packer (DATA_W=32, MAX_LEN=16, LEN_W=5).
//   Directed vectors come from a table; a random stream is checked against a
//   bit-level reference model; expected words flow through a scoreboard queue.
`timescale 1ns/1ps

module tb_vlc_bit_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef VLC_PACK_BITCNT_EN
    logic [31:0] bit_count;
`endif

    vlc_bit_packer_if #(.DATA_W(32), .MAX_LEN(16), .LEN_W(5)) bus ();

    vlc_bit_packer #(.DATA_W(32), .MAX_LEN(16), .LEN_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus)
`ifdef VLC_PACK_BITCNT_EN
        ,
        .bit_count (bit_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  bytes;
        logic        last;
    } word_t;

    typedef struct {
        logic [15:0] code;
        logic [4:0]  len;
        logic        flush;
        int          n;
        logic [31:0] d0;
        logic [2:0]  b0;
        logic        l0;
        logic [31:0] d1;
        logic [2:0]  b1;
        logic        l1;
        logic        err;
        logic [31:0] bc;
    } vec_t;

    int    n_checks = 0;
    int    n_fail   = 0;
    int    ready_mode = 1;   // 0 hold low, 1 hold high, 2 random
    word_t sb[$];
    logic  mbits[$];
    bit    mon_stall = 1'b0;
    word_t mon_held;
    vec_t  vecs[16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] c, input logic [4:0] l, input logic f,
                                input int n, input logic [31:0] d0, input logic [2:0] b0,
                                input logic l0, input logic [31:0] d1, input logic [2:0] b1,
                                input logic l1, input logic err, input logic [31:0] bc);
        vec_t v;
        v.code = c; v.len = l; v.flush = f; v.n = n;
        v.d0 = d0; v.b0 = b0; v.l0 = l0; v.d1 = d1; v.b1 = b1; v.l1 = l1;
        v.err = err; v.bc = bc;
        return v;
    endfunction

    // Reference: plain bit queue, MSB-first.
    task automatic model_pop_word(input logic last);
        word_t w;
        w.data = '0;
        for (int i = 31; i >= 0; i--) w.data[i] = mbits.pop_front();
        w.bytes = 3'd4;
        w.last  = last;
        sb.push_back(w);
    endtask

    task automatic model_beat(input logic [15:0] c, input logic [4:0] l, input logic f);
        int    lc;
        int    n;
        word_t w;
        lc = (l > 5'd16) ? 16 : int'(l);
        for (int i = lc - 1; i >= 0; i--) mbits.push_back(c[i]);
        if (!f) begin
            while (mbits.size() >= 32) model_pop_word(1'b0);
        end else begin
            while (mbits.size() > 32) model_pop_word(1'b0);
            if (mbits.size() == 32) begin
                model_pop_word(1'b1);
            end else begin
                n = mbits.size();
                w.data = '0;
                for (int i = 0; i < n; i++) w.data[31-i] = mbits.pop_front();
                w.bytes = 3'((n + 7) / 8);
                w.last  = 1'b1;
                sb.push_back(w);
            end
        end
    endtask

    // Returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [15:0] c, input logic [4:0] l, input logic f);
        int unsigned w = 0;
        bus.in_valid = 1'b1;
        bus.in_code  = c;
        bus.in_len   = l;
        bus.in_flush = f;
        @(negedge clk);
        while (!bus.in_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("send in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_flush = 1'b0;
        bus.in_code  = 16'($urandom);
        bus.in_len   = 5'($urandom);
    endtask

    task automatic drain(input string tag);
        int unsigned w = 0;
        while (sb.size() != 0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check({tag, " drained"}, 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, " out_data"},  64'(bus.out_data),  64'd0);
        check({tag, " out_bytes"}, 64'(bus.out_bytes), 64'd0);
        check({tag, " out_last"},  64'(bus.out_last),  64'd0);
        check({tag, " len_err"},   64'(bus.len_err),   64'd0);
`ifdef VLC_PACK_BITCNT_EN
        check({tag, " bit_count"}, 64'(bit_count),     64'd0);
`endif
    endtask

    // Downstream ready driver.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b0;
                1:       bus.out_ready = 1'b1;
                default: bus.out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: scoreboard pop on handshake, stability while stalled.
    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_stall = 1'b0;
            end else begin
                if (mon_stall) begin
                    check("stall valid", 64'(bus.out_valid), 64'd1);
                    check("stall data",  64'(bus.out_data),  64'(mon_held.data));
                    check("stall bytes", 64'(bus.out_bytes), 64'(mon_held.bytes));
                    check("stall last",  64'(bus.out_last),  64'(mon_held.last));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected word valid", 64'(bus.out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        check("word data",  64'(bus.out_data),  64'(e.data));
                        check("word bytes", 64'(bus.out_bytes), 64'(e.bytes));
                        check("word last",  64'(bus.out_last),  64'(e.last));
                    end
                end
                mon_stall      = bus.out_valid && !bus.out_ready;
                mon_held.data  = bus.out_data;
                mon_held.bytes = bus.out_bytes;
                mon_held.last  = bus.out_last;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] c;
        logic [4:0]  l;
        int          seen;

        //          code      len   fl  n  d0            b0    l0    d1            b1    l1    err   bc
        vecs[0]  = mk(16'h00AB, 5'd8,  1'b0, 0, 32'h0,        3'd0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'd8);
        vecs[1]  = mk(16'h00CD, 5'd8,  1'b0, 0, 32'h0,        3'd0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'd16);
        vecs[2]  = mk(16'h00EF, 5'd8,  1'b0, 0, 32'h0,        3'd0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'd24);
        vecs[3]  = mk(16'h0001, 5'd8,  1'b1, 1, 32'hABCDEF01, 3'd4, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 32'd32);
        vecs[4]  = mk(16'h0005, 5'd3,  1'b1, 1, 32'hA0000000, 3'd1, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 32'd3);
        vecs[5]  = mk(16'hFFFD, 5'd3,  1'b1, 1, 32'hA0000000, 3'd1, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 32'd3);
        vecs[6]  = mk(16'h1234, 5'd16, 1'b0, 0, 32'h0,        3'd0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'd16);
        vecs[7]  = mk(16'h5678, 5'd16, 1'b0, 1, 32'h12345678, 3'd4, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'd32);
        vecs[8]  = mk(16'h9ABC, 5'd16, 1'b0, 0, 32'h0,        3'd0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'd48);
        vecs[9]  = mk(16'h0000, 5'd0,  1'b1, 1, 32'h9ABC0000, 3'd2, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 32'd48);
        vecs[10] = mk(16'hAAAA, 5'd16, 1'b0, 0, 32'h0,        3'd0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'd16);
        vecs[11] = mk(16'h7FFF, 5'd15, 1'b0, 0, 32'h0,        3'd0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b0, 32'd31);
        vecs[12] = mk(16'h1234, 5'd16, 1'b1, 2, 32'hAAAAFFFE, 3'd4, 1'b0, 32'h24680000, 3'd2, 1'b1, 1'b0, 32'd47);
        vecs[13] = mk(16'h0000, 5'd0,  1'b1, 1, 32'h00000000, 3'd0, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 32'd0);
        vecs[14] = mk(16'hBEEF, 5'd20, 1'b0, 0, 32'h0,        3'd0, 1'b0, 32'h0,        3'd0, 1'b0, 1'b1, 32'd16);
        vecs[15] = mk(16'h0000, 5'd0,  1'b1, 1, 32'hBEEF0000, 3'd2, 1'b1, 32'h0,        3'd0, 1'b0, 1'b1, 32'd16);

        bus.in_valid = 1'b0;
        bus.in_code  = '0;
        bus.in_len   = '0;
        bus.in_flush = 1'b0;
        ready_mode   = 1;

        // Power-on reset.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_ready during reset", 64'(bus.in_ready), 64'd0);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready after reset", 64'(bus.in_ready), 64'd1);
        check_reset_outputs("post-reset");

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].n >= 1) sb.push_back('{vecs[i].d0, vecs[i].b0, vecs[i].l0});
            if (vecs[i].n >= 2) sb.push_back('{vecs[i].d1, vecs[i].b1, vecs[i].l1});
            send(vecs[i].code, vecs[i].len, vecs[i].flush);
            check($sformatf("vec%0d len_err", i), 64'(bus.len_err), 64'(vecs[i].err));
`ifdef VLC_PACK_BITCNT_EN
            check($sformatf("vec%0d bit_count", i), 64'(bit_count), 64'(vecs[i].bc));
`endif
        end
        drain("table");

        // Random stream with random back-pressure.
        ready_mode = 2;
        for (int i = 0; i < 200; i++) begin
            c = 16'($urandom);
            l = 5'($urandom_range(1, 16));
            model_beat(c, l, 1'b0);
            send(c, l, 1'b0);
        end
        c = 16'($urandom);
        model_beat(c, 5'd1, 1'b1);
        send(c, 5'd1, 1'b1);
        drain("random");

        // Reset with fill=20 and a stalled output word.
        ready_mode = 0;
        @(posedge clk);
        #1;
        send(16'hFFFF, 5'd16, 1'b0);
        send(16'h0F0F, 5'd16, 1'b0);
        send(16'h1111, 5'd16, 1'b0);
        send(16'h0002, 5'd4,  1'b0);
        check("pre-reset stalled valid", 64'(bus.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid reset in_ready", 64'(bus.in_ready), 64'd0);
        check_reset_outputs("mid reset");
        sb.delete();
        mbits.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ready_mode = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("words after reset release", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        sb.push_back('{32'hFF000000, 3'd1, 1'b1});
        send(16'h00FF, 5'd8, 1'b1);
        drain("post-reset frame");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
